ex_stage: RTL and testbench



---
 rtl/alu_defs_pkg.sv | 21 ++
 rtl/ex_stage_sll_serial.sv | 57 +++++
 rtl/ex_stage.sv | 166 ++++++++++++++++
 tb/tb_ex_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Shared ALU control-code definitions for the ALU control unit and the execute stage.
package alu_defs;

  localparam int WIDTH_DEF = 32;
  localparam int SHW_DEF   = 5;

  typedef logic [2:0] alu_ctr_t;

  localparam alu_ctr_t ALU_AND = 3'b000;
  localparam alu_ctr_t ALU_OR  = 3'b001;
  localparam alu_ctr_t ALU_ADD = 3'b010;
  localparam alu_ctr_t ALU_SUB = 3'b110;
  localparam alu_ctr_t ALU_SLT = 3'b111;
  localparam alu_ctr_t ALU_SLL = 3'b101;

  // 011 and 100 are unassigned encodings; the execute stage squashes them.
  function automatic logic is_reserved(input alu_ctr_t ctr);
    return (ctr == 3'b011) || (ctr == 3'b100);
  endfunction

endpackage

// File: rtl/ex_stage_sll_serial.sv
// Bit-serial left shifter: one position per cycle, final shifted word offered on done.
module sll_serial
  import alu_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   count_q, count_d;
  logic             busy_q, busy_d;

  always_comb begin
    work_d  = work_q;
    count_d = count_q;
    busy_d  = busy_q;
    if (flush) begin
      busy_d = 1'b0;
    end else if (start) begin
      work_d  = din;
      count_d = shamt;
      busy_d  = (shamt != '0);
    end else if (busy_q) begin
      work_d  = {work_q[WIDTH-2:0], 1'b0};
      count_d = count_q - 1'b1;
      if (count_q == SHW'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      work_q  <= work_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  // The last shift is folded into dout so the result lands k cycles after start.
  assign busy = busy_q;
  assign done = busy_q && (count_q == SHW'(1));
  assign dout = {work_q[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle AND/OR/ADD/SUB/SLT, serial SLL, held result with valid/ready.
module ex_stage
  import alu_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [SHW-1:0]   shamt,
  input  logic [4:0]       rd_in,
  input  logic             reg_write_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ex_result,
  output logic             ex_zero,
  output logic             ex_ovf,
  output logic             ex_illegal,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;
  logic [4:0]       rd_q, rd_d;
  logic             reg_write_q, reg_write_d;

  logic                    accept;
  logic                    sll_start;
  logic                    sh_busy, sh_done;
  logic [WIDTH-1:0]        sh_dout;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_ovf;
  logic signed [WIDTH-1:0] a_s, b_s, sum_s, diff_s;

  assign in_ready  = !flush && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign sll_start = accept && (alu_ctr == ALU_SLL) && (shamt != '0);

  assign a_s    = op_a;
  assign b_s    = op_b;
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;

  // Overflow only when the operand signs allow it and the wrapped sign disagrees with op_a.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_ctr)
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_ADD: begin
        alu_res = sum_s;
        alu_ovf = add_ovf(op_a[WIDTH-1], op_b[WIDTH-1], sum_s[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff_s;
        alu_ovf = sub_ovf(op_a[WIDTH-1], op_b[WIDTH-1], diff_s[WIDTH-1]);
      end
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLL: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  sll_serial #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_sll (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .start (sll_start),
    .din   (op_b),
    .shamt (shamt),
    .busy  (sh_busy),
    .done  (sh_done),
    .dout  (sh_dout)
  );

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    if (flush) begin
      state_d     = ST_IDLE;
      reg_write_d = 1'b0;
    end else begin
      if ((state_q == ST_HOLD) && out_ready) state_d = ST_IDLE;
      if ((state_q == ST_SHIFT) && sh_busy && sh_done) begin
        result_d = sh_dout;
        zero_d   = (sh_dout == '0);
        ovf_d    = 1'b0;
        state_d  = ST_HOLD;
      end
      // Destination info is captured at accept so it is already in place when a shift completes.
      if (accept) begin
        rd_d        = rd_in;
        illegal_d   = is_reserved(alu_ctr);
        reg_write_d = reg_write_in && !is_reserved(alu_ctr);
        if (sll_start) begin
          state_d = ST_SHIFT;
        end else begin
          result_d = alu_res;
          zero_d   = (alu_res == '0);
          ovf_d    = alu_ovf;
          state_d  = ST_HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign out_valid    = (state_q == ST_HOLD);
  assign ex_result    = result_q;
  assign ex_zero      = zero_q;
  assign ex_ovf       = ovf_q;
  assign ex_illegal   = illegal_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = reg_write_q;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against a cycle-level behavioural model of the execute stage.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, reg_write_in;
  logic        in_ready, out_valid, ex_zero, ex_ovf, ex_illegal, ex_reg_write;
  logic [2:0]  alu_ctr;
  logic [31:0] op_a, op_b, ex_result;
  logic [4:0]  shamt, rd_in, ex_rd;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: held result, remaining shift cycles, captured outputs.
  logic        m_known = 1'b0, m_just_reset = 1'b0, m_hold = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_res = '0;
  logic        m_zero = 1'b0, m_ovf = 1'b0, m_ill = 1'b0, m_rw = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] held;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(32), .SHW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_ctr      (alu_ctr),
    .op_a         (op_a),
    .op_b         (op_b),
    .shamt        (shamt),
    .rd_in        (rd_in),
    .reg_write_in (reg_write_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ex_result    (ex_result),
    .ex_zero      (ex_zero),
    .ex_ovf       (ex_ovf),
    .ex_illegal   (ex_illegal),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU using 64-bit signed arithmetic for overflow and comparison.
  task automatic ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] r, output logic o);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    o = 1'b0;
    case (c)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd6: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd7: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd5: r = b << sh;
      default: r = '0;
    endcase
  endtask

  // Inputs are already set; check outputs before the edge, then advance the model across it.
  task automatic step();
    logic        exp_ready, acc, o;
    logic [31:0] r;
    #1;
    exp_ready = !flush && ((!m_hold && m_cnt == 0) || (m_hold && out_ready));
    if (m_known) begin
      check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
      check_eq("out_valid", 32'(out_valid), 32'(m_hold));
      check_eq("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
      if (m_hold) begin
        check_eq("ex_result", ex_result, m_res);
        check_eq("ex_zero", 32'(ex_zero), 32'(m_zero));
        check_eq("ex_ovf", 32'(ex_ovf), 32'(m_ovf));
        check_eq("ex_illegal", 32'(ex_illegal), 32'(m_ill));
        check_eq("ex_rd", 32'(ex_rd), 32'(m_rd));
      end
      if (m_just_reset) begin
        check_eq("rst_result", ex_result, 32'd0);
        check_eq("rst_zero", 32'(ex_zero), 32'd0);
        check_eq("rst_ovf", 32'(ex_ovf), 32'd0);
        check_eq("rst_illegal", 32'(ex_illegal), 32'd0);
        check_eq("rst_rd", 32'(ex_rd), 32'd0);
      end
    end
    acc = in_valid && exp_ready;
    @(posedge clk);
    m_just_reset = 1'b0;
    if (reset) begin
      m_known = 1'b1; m_just_reset = 1'b1; m_hold = 1'b0; m_cnt = 0; m_rw = 1'b0;
    end else if (flush) begin
      m_hold = 1'b0; m_cnt = 0; m_rw = 1'b0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_hold = 1'b1;
      end else if (m_hold && out_ready) begin
        m_hold = 1'b0;
      end
      if (acc) begin
        ref_alu(alu_ctr, op_a, op_b, shamt, r, o);
        m_ill  = (alu_ctr == 3'b011) || (alu_ctr == 3'b100);
        m_rd   = rd_in;
        m_rw   = reg_write_in && !m_ill;
        m_res  = r;
        m_zero = (r == 32'd0);
        m_ovf  = o;
        if (alu_ctr == 3'b101 && shamt != 5'd0) begin
          m_cnt = int'(shamt); m_hold = 1'b0;
        end else begin
          m_hold = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
    in_valid = 1'b1; alu_ctr = c; op_a = a; op_b = b; shamt = sh;
    rd_in = 5'($urandom_range(1, 31)); reg_write_in = 1'b1;
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom % 5)
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom % 4);
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctr = '0; op_a = '0; op_b = '0; shamt = '0; rd_in = '0; reg_write_in = 1'b0;
    @(negedge clk);
    step(); step();
    reset = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    set_op(3'b010, 32'h7FFF_FFFF, 32'd1, 5'd0); step();
    check_eq("add_res", ex_result, 32'h8000_0000);
    check_eq("add_ovf", 32'(ex_ovf), 32'd1);
    check_eq("add_zero", 32'(ex_zero), 32'd0);
    set_op(3'b110, 32'd5, 32'd5, 5'd0); step();
    check_eq("sub_zero", 32'(ex_zero), 32'd1);
    check_eq("sub_res", ex_result, 32'd0);
    set_op(3'b111, 32'hFFFF_FFFF, 32'd1, 5'd0); step();
    check_eq("slt_neg", ex_result, 32'd1);
    set_op(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0); step();
    check_eq("slt_ovf", ex_result, 32'd1);

    set_op(3'b101, 32'd0, 32'd1, 5'd31); step();
    set_op(3'b010, 32'd3, 32'd4, 5'd0);
    for (int i = 0; i < 30; i++) step();
    check_eq("sll31_early", 32'(out_valid), 32'd0);
    step();
    check_eq("sll31_valid", 32'(out_valid), 32'd1);
    check_eq("sll31_res", ex_result, 32'h8000_0000);
    in_valid = 1'b0; step();
    set_op(3'b101, 32'd0, 32'h0000_1234, 5'd0); step();
    check_eq("sll0_res", ex_result, 32'h0000_1234);

    set_op(3'b010, 32'd100, 32'd23, 5'd0); step();
    held = ex_result;
    out_ready = 1'b0;
    set_op(3'b001, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0);
    for (int i = 0; i < 5; i++) step();
    check_eq("bp_held", ex_result, held);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1; step();
    check_eq("bp_or_res", ex_result, 32'hF0F0_0F0F);
    check_eq("bp_or_valid", 32'(out_valid), 32'd1);

    set_op(3'b101, 32'd0, 32'd7, 5'd20); step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    flush = 1'b1; set_op(3'b000, 32'hFF, 32'h0F, 5'd0); step();
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_rw", 32'(ex_reg_write), 32'd0);
    flush = 1'b0; in_valid = 1'b0; step();

    set_op(3'b011, 32'h1234, 32'h5678, 5'd0); reg_write_in = 1'b1; step();
    check_eq("ill_res", ex_result, 32'd0);
    check_eq("ill_flag", 32'(ex_illegal), 32'd1);
    check_eq("ill_rw", 32'(ex_reg_write), 32'd0);
    set_op(3'b001, 32'h55, 32'hAA, 5'd0); step();
    reset = 1'b1; in_valid = 1'b0; step();
    check_eq("rst_ov_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ov_res", ex_result, 32'd0);
    check_eq("rst_ov_rd", 32'(ex_rd), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom % 300) == 0;
      flush        = ($urandom % 25) == 0;
      out_ready    = ($urandom % 4) != 0;
      in_valid     = ($urandom % 10) < 7;
      alu_ctr      = 3'($urandom);
      op_a         = rnd_word();
      op_b         = rnd_word();
      shamt        = (($urandom % 2) == 0) ? 5'($urandom % 4) : 5'($urandom);
      rd_in        = 5'($urandom);
      reg_write_in = 1'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
